// File: rtl/vga_sync_rx_if.sv
// Link between a VGA timing source and the vga_sync_rx receiver: sync/data in,
// recovered pixel stream and timing status out.
interface vga_sync_rx_if;
    logic        HSYNC;
    logic        VSYNC;
    logic [15:0] DATA_IN;
    logic        ERR_CLR;
    logic        PIX_VALID;
    logic [15:0] PIX_DATA;
    logic [10:0] PIX_X;
    logic [9:0]  PIX_Y;
    logic        LINE_START;
    logic        FRAME_START;
    logic        LOCKED;
    logic [15:0] H_PERIOD;
    logic [15:0] V_LINES;
    logic        TIMING_ERR;

    modport master (
        output HSYNC, VSYNC, DATA_IN, ERR_CLR,
        input  PIX_VALID, PIX_DATA, PIX_X, PIX_Y, LINE_START, FRAME_START,
        input  LOCKED, H_PERIOD, V_LINES, TIMING_ERR
    );

    modport slave (
        input  HSYNC, VSYNC, DATA_IN, ERR_CLR,
        output PIX_VALID, PIX_DATA, PIX_X, PIX_Y, LINE_START, FRAME_START,
        output LOCKED, H_PERIOD, V_LINES, TIMING_ERR
    );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: recovers pixel X/Y from HSYNC/VSYNC, locks to the expected
// line/frame timing, emits a pixel-valid stream and flags timing errors.
module vga_sync_rx #(
    parameter int H_TOTAL   = 1057,
    parameter int V_TOTAL   = 629,
    parameter int H_ACT_OFS = 218,
    parameter int H_ACT_LEN = 799,
    parameter int V_ACT_OFS = 28,
    parameter int V_ACT_LEN = 599
) (
    input  logic         CLK_40M,
    input  logic         RST_N,
    vga_sync_rx_if.slave bus
);

    localparam logic [15:0] H_TOTAL_W = 16'(H_TOTAL);
    localparam logic [15:0] V_TOTAL_W = 16'(V_TOTAL);
    localparam logic [15:0] H_WDOG    = 16'(2 * H_TOTAL);
    localparam logic [15:0] H_ACT_LO  = 16'(H_ACT_OFS);
    localparam logic [15:0] H_ACT_HI  = 16'(H_ACT_OFS + H_ACT_LEN - 1);
    localparam logic [15:0] V_ACT_LO  = 16'(V_ACT_OFS);
    localparam logic [15:0] V_ACT_HI  = 16'(V_ACT_OFS + V_ACT_LEN - 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_ACQUIRE, ST_LOCKED} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        hs_s1, hs_s2, vs_s1, vs_s2;
    logic [15:0] data_s1;
    logic [15:0] h_cnt, line_cnt, h_cur, line_cur, h_meas, v_meas;
    logic        h_fall, v_fall, h_bad, v_bad, wdog, active;
    state_t      state_q, state_d;
    logic        skip_q, skip_d, herr_q, herr_d, err_set;
    logic        err_q, pix_valid_q, line_start_q, frame_start_q;
    logic [15:0] pix_data_q, h_period_q, v_lines_q;
    logic [10:0] pix_x_q;
    logic [9:0]  pix_y_q;

    // NOTE: sync sample registers reset to 1 so the idle-high lines do not look like a fall after reset.
    always_ff @(posedge CLK_40M or negedge RST_N) begin
        if (!RST_N) begin
            hs_s1   <= 1'b1;
            hs_s2   <= 1'b1;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            data_s1 <= '0;
        end else begin
            hs_s1   <= bus.HSYNC;
            hs_s2   <= hs_s1;
            vs_s1   <= bus.VSYNC;
            vs_s2   <= vs_s1;
            data_s1 <= bus.DATA_IN;
        end
    end

    // h_cur/line_cur are the coordinates of the sample currently held in s1.
    assign h_fall   = hs_s2 & ~hs_s1;
    assign v_fall   = vs_s2 & ~vs_s1;
    assign h_meas   = sat_inc(h_cnt);
    assign v_meas   = sat_inc(line_cnt);
    assign h_cur    = h_fall ? 16'd0 : h_meas;
    assign line_cur = v_fall ? 16'd0 : (h_fall ? v_meas : line_cnt);
    assign h_bad    = h_fall && (h_meas != H_TOTAL_W);
    assign v_bad    = v_fall && (v_meas != V_TOTAL_W);
    assign wdog     = (h_cur == H_WDOG);

    always_ff @(posedge CLK_40M or negedge RST_N) begin
        if (!RST_N) begin
            h_cnt      <= '0;
            line_cnt   <= '0;
            h_period_q <= '0;
            v_lines_q  <= '0;
        end else begin
            h_cnt    <= h_cur;
            line_cnt <= line_cur;
            if (h_fall) h_period_q <= h_meas;
            if (v_fall) v_lines_q  <= v_meas;
        end
    end

    always_ff @(posedge CLK_40M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_SEARCH;
            skip_q  <= 1'b0;
            herr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            herr_q  <= herr_d;
        end
    end

    // NOTE: every variable gets its default before the case so no latches are inferred.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        herr_d  = herr_q;
        err_set = 1'b0;
        if (wdog) begin
            state_d = ST_SEARCH;
            err_set = (state_q == ST_LOCKED);
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (v_fall) begin
                        state_d = ST_ACQUIRE;
                        skip_d  = 1'b1;
                        herr_d  = 1'b0;
                    end
                end
                ST_ACQUIRE: begin
                    // The first line after entry may be partial, so its length is not judged.
                    if (h_fall) begin
                        if (skip_q) skip_d = 1'b0;
                        else if (h_bad) herr_d = 1'b1;
                    end
                    if (v_fall) begin
                        if (!herr_d && !v_bad) state_d = ST_LOCKED;
                        herr_d = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    if (h_bad || v_bad) begin
                        state_d = ST_ACQUIRE;
                        skip_d  = 1'b1;
                        herr_d  = 1'b0;
                        err_set = 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    assign active = (state_q == ST_LOCKED) &&
                    (h_cur >= H_ACT_LO) && (h_cur <= H_ACT_HI) &&
                    (line_cur >= V_ACT_LO) && (line_cur <= V_ACT_HI);

    always_ff @(posedge CLK_40M or negedge RST_N) begin
        if (!RST_N) begin
            err_q         <= 1'b0;
            pix_valid_q   <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            if (err_set)          err_q <= 1'b1;
            else if (bus.ERR_CLR) err_q <= 1'b0;
            pix_valid_q   <= active;
            line_start_q  <= active && (h_cur == H_ACT_LO);
            frame_start_q <= active && (h_cur == H_ACT_LO) && (line_cur == V_ACT_LO);
            if (active) begin
                pix_data_q <= data_s1;
                pix_x_q    <= 11'(h_cur - H_ACT_LO);
                pix_y_q    <= 10'(line_cur - V_ACT_LO);
            end
        end
    end

    assign bus.PIX_VALID   = pix_valid_q;
    assign bus.PIX_DATA    = pix_data_q;
    assign bus.PIX_X       = pix_x_q;
    assign bus.PIX_Y       = pix_y_q;
    assign bus.LINE_START  = line_start_q;
    assign bus.FRAME_START = frame_start_q;
    assign bus.LOCKED      = (state_q == ST_LOCKED);
    assign bus.H_PERIOD    = h_period_q;
    assign bus.V_LINES     = v_lines_q;
    assign bus.TIMING_ERR  = err_q;

endmodule
